// File: rtl/dmem_rmw_port.sv
// Data-memory port below the MEM stage: loads are one bus read, stores are read-merge-write on a req/ack word bus.
// Optional build macro DMEM_STATS_EN adds retired-load/store and stall-cycle counters.
module dmem_rmw_port #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] data_address_2DM,
    input  logic [31:0] data_write_2DM,
    input  logic [1:0]  data_write_size_2DM,
    input  logic        MemRead_2DM,
    input  logic        MemWrite_2DM,
    output logic [31:0] data_read_fDM,
    output logic        dmem_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic [31:0] stat_loads,
    output logic [31:0] stat_stores,
    output logic [31:0] stat_stall_cycles
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MERGE,
        S_WR,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             is_store;
    logic [1:0]       offset_q;
    logic [1:0]       size_q;
    logic             request;
    logic             timeout;

    assign request    = MemRead_2DM | MemWrite_2DM;
    assign timeout    = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign dmem_stall = (state == S_IDLE) ? request : (state != S_DONE);

    // Byte lanes [offset, offset+size) with be[3] as byte 0; lanes past the word end fall off the shift.
    function automatic logic [3:0] lane_mask(input logic [1:0] offset, input logic [1:0] size);
        logic [2:0] span;
        logic [2:0] last;
        span      = (size == 2'd0) ? 3'd4 : {1'b0, size};
        last      = 3'(offset) + span;
        lane_mask = (4'b1111 >> offset) & ~(4'b1111 >> last);
    endfunction

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            is_store      <= 1'b0;
            offset_q      <= 2'd0;
            size_q        <= 2'd0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= 30'd0;
            mem_be        <= 4'd0;
            mem_wdata     <= 32'd0;
            data_read_fDM <= 32'd0;
            mem_error     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (request) begin
                        mem_addr <= data_address_2DM[31:2];
                        offset_q <= data_address_2DM[1:0];
                        size_q   <= data_write_size_2DM;
                        is_store <= MemWrite_2DM;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_be   <= 4'b1111;
                        wait_cnt <= '0;
                        state    <= S_RD;
                    end
                end
                S_RD: begin
                    if (mem_ack) begin
                        data_read_fDM <= mem_rdata;
                        mem_req       <= 1'b0;
                        state         <= is_store ? S_MERGE : S_DONE;
                    end else if (timeout) begin
                        data_read_fDM <= ERR_DATA;
                        mem_req       <= 1'b0;
                        mem_error     <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                // MEM has re-merged against data_read_fDM by now; capture its word for the write.
                S_MERGE: begin
                    mem_wdata <= data_write_2DM;
                    mem_we    <= 1'b1;
                    mem_be    <= lane_mask(offset_q, size_q);
                    mem_req   <= 1'b1;
                    wait_cnt  <= '0;
                    state     <= S_WR;
                end
                S_WR: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= S_DONE;
                    end else if (timeout) begin
                        mem_req   <= 1'b0;
                        mem_error <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DMEM_STATS_EN
    // Retirement counts bump in DONE; stall cycles count every stalled cycle.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            stat_loads        <= 32'd0;
            stat_stores       <= 32'd0;
            stat_stall_cycles <= 32'd0;
        end else begin
            if (state == S_DONE) begin
                if (is_store) stat_stores <= stat_stores + 32'd1;
                else          stat_loads  <= stat_loads + 32'd1;
            end
            if (dmem_stall) stat_stall_cycles <= stat_stall_cycles + 32'd1;
        end
    end
`else
    assign stat_loads        = 32'd0;
    assign stat_stores       = 32'd0;
    assign stat_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_dmem_rmw_port.sv
// Randomized bench for dmem_rmw_port: the bench acts as MEM stage and bus slave and checks against a word-memory model.
module tb_dmem_rmw_port;

    localparam int unsigned TO  = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;
    localparam int          NEVER = 1000;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] data_address_2DM = '0;
    logic [31:0] data_write_2DM = '0;
    logic [1:0]  data_write_size_2DM = '0;
    logic        MemRead_2DM = 1'b0;
    logic        MemWrite_2DM = 1'b0;
    logic [31:0] data_read_fDM;
    logic        dmem_stall;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_error;
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_stall_cycles;

    dmem_rmw_port #(.TIMEOUT_CYCLES(TO), .ERR_DATA(ERR)) dut (
        .CLK(CLK), .RESET(RESET),
        .data_address_2DM(data_address_2DM), .data_write_2DM(data_write_2DM),
        .data_write_size_2DM(data_write_size_2DM),
        .MemRead_2DM(MemRead_2DM), .MemWrite_2DM(MemWrite_2DM),
        .data_read_fDM(data_read_fDM), .dmem_stall(dmem_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_error(mem_error),
        .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_stall_cycles(stat_stall_cycles)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    bit exp_err = 1'b0;
    int exp_loads = 0;
    int exp_stores = 0;
    int exp_stalls = 0;

    logic [31:0] slave_mem [logic [29:0]];
    logic [31:0] model_mem [logic [29:0]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] seed_word(input logic [29:0] a);
        return {2'b10, a} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] slave_rd(input logic [29:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : seed_word(a);
    endfunction

    function automatic logic [31:0] model_rd(input logic [29:0] a);
        return model_mem.exists(a) ? model_mem[a] : seed_word(a);
    endfunction

    // Expected lanes: bytes k with offset <= k < offset+n, byte k being be[3-k].
    function automatic logic [3:0] exp_lanes(input logic [1:0] off, input logic [1:0] size);
        int n;
        logic [3:0] be;
        n  = (size == 2'd0) ? 4 : int'(size);
        be = 4'b0000;
        for (int k = 0; k < 4; k++)
            if (k >= int'(off) && k < int'(off) + n) be[3-k] = 1'b1;
        return be;
    endfunction

    task automatic slave_write(input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] w;
        w = slave_rd(a);
        for (int b = 0; b < 4; b++)
            if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        slave_mem[a] = w;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] d);
        logic [31:0] w;
        int n;
        n = (size == 2'd0) ? 4 : int'(size);
        w = model_rd(addr[31:2]);
        for (int k = int'(addr[1:0]); k < 4 && k < int'(addr[1:0]) + n; k++)
            w[31-8*k -: 8] = d[31-8*k -: 8];
        model_mem[addr[31:2]] = w;
    endtask

    task automatic check_stats(input int l, input int s, input int st);
`ifdef DMEM_STATS_EN
        check_eq("stat_loads", stat_loads, 32'(l));
        check_eq("stat_stores", stat_stores, 32'(s));
        check_eq("stat_stall_cycles", stat_stall_cycles, 32'(st));
`else
        check_eq("stat_loads_off", stat_loads, 32'd0);
        check_eq("stat_stores_off", stat_stores, 32'd0);
        check_eq("stat_stall_off", stat_stall_cycles, 32'(l - l + s - s + st - st));
`endif
    endtask

    // One MEM-stage access; caller is at a negedge, returns at the negedge after DONE with requests dropped.
    task automatic run_access(input bit store, input logic [31:0] addr, input logic [1:0] size,
                              input logic [31:0] wdata, input int rd_delay, input int wr_delay);
        int stalls, rd_n, wr_n, want;
        bit done, rd_to, wr_to;
        logic [31:0] old;
        old   = model_rd(addr[31:2]);
        rd_to = (rd_delay >= int'(TO));
        wr_to = (wr_delay >= int'(TO));
        MemRead_2DM = !store; MemWrite_2DM = store;
        data_address_2DM = addr; data_write_size_2DM = size; data_write_2DM = wdata;
        mem_ack = 1'b0;
        stalls = 0; rd_n = 0; wr_n = 0; done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            #1;
            mem_ack = 1'b0;
            if (!dmem_stall) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (mem_req && !mem_we) begin
                    if (rd_n == rd_delay) begin
                        check_eq("rd_addr", 32'(mem_addr), 32'(addr[31:2]));
                        check_eq("rd_be", 32'(mem_be), 32'hF);
                        mem_rdata = slave_rd(mem_addr);
                        mem_ack = 1'b1;
                    end
                    rd_n++;
                end else if (mem_req && mem_we) begin
                    if (wr_n == wr_delay) begin
                        check_eq("wr_addr", 32'(mem_addr), 32'(addr[31:2]));
                        check_eq("wr_be", 32'(mem_be), 32'(exp_lanes(addr[1:0], size)));
                        check_eq("wr_data", mem_wdata, wdata);
                        slave_write(mem_addr, mem_be, mem_wdata);
                        mem_ack = 1'b1;
                    end
                    wr_n++;
                end
                @(negedge CLK);
            end
        end
        check_eq("access_done", 32'(done), 32'd1);
        if (!store) want = 1 + (rd_to ? int'(TO) : rd_delay + 1);
        else want = 1 + (rd_to ? int'(TO) : rd_delay + 2 + (wr_to ? int'(TO) : wr_delay + 1));
        check_eq("stall_cycles", 32'(stalls), 32'(want));
        check_eq("read_data", data_read_fDM, rd_to ? ERR : old);
        check_eq("done_req_low", 32'(mem_req), 32'd0);
        if (rd_to || (store && wr_to)) exp_err = 1'b1;
        check_eq("mem_error", 32'(mem_error), 32'(exp_err));
        if (store && !rd_to && !wr_to) model_write(addr, size, wdata);
        if (store) exp_stores++; else exp_loads++;
        exp_stalls += want;
        @(negedge CLK);
        MemRead_2DM = 1'b0; MemWrite_2DM = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        logic [31:0] a;
        int d1, d2;
        repeat (2) @(negedge CLK);
        #1;
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_be", 32'(mem_be), 32'd0);
        check_eq("rst_rdata", data_read_fDM, 32'd0);
        check_eq("rst_err", 32'(mem_error), 32'd0);
        check_eq("rst_stall", 32'(dmem_stall), 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);

        // Reset asserted mid-write drops the bus request at once.
        MemWrite_2DM = 1'b1; data_address_2DM = 32'h300; data_write_size_2DM = 2'd0;
        data_write_2DM = 32'h01020304;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            mem_ack = 1'b0;
            if (mem_req && mem_we) seen = 1'b1;
            else begin
                if (mem_req) begin mem_rdata = 32'h0BAD_0BAD; mem_ack = 1'b1; end
                @(negedge CLK);
            end
        end
        check_eq("rst_reach_wr", 32'(seen), 32'd1);
        RESET = 1'b0;
        #1;
        check_eq("rst_mid_req", 32'(mem_req), 32'd0);
        check_eq("rst_mid_we", 32'(mem_we), 32'd0);
        MemWrite_2DM = 1'b0;
        #1;
        check_eq("rst_mid_stall", 32'(dmem_stall), 32'd0);
        @(negedge CLK);
        RESET = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        @(negedge CLK);
        mem_ack = 1'b0;
        #1;
        check_eq("stray_ack_req", 32'(mem_req), 32'd0);
        check_eq("stray_ack_rdata", data_read_fDM, 32'd0);
        check_eq("stray_ack_stall", 32'(dmem_stall), 32'd0);
        @(negedge CLK);

        // Zero-wait mix: 3 loads + 2 stores -> 3*2 + 2*4 stall cycles.
        for (int i = 0; i < 3; i++) run_access(1'b0, 32'h40 + 32'(4 * i), 2'd0, 32'd0, 0, 0);
        run_access(1'b1, 32'h52, 2'd2, 32'hCAFE_F00D, 0, 0);
        run_access(1'b1, 32'h40, 2'd0, 32'h1234_5678, 0, 0);
        check_stats(3, 2, 14);

        slave_mem[30'h40] = 32'h11223344; model_mem[30'h40] = 32'h11223344;
        run_access(1'b0, 32'h100, 2'd0, 32'd0, 1, 0);
        check_eq("t1_rdata", data_read_fDM, 32'h11223344);
        run_access(1'b1, 32'h203, 2'd1, 32'hAABBCC55, 0, 0);
        run_access(1'b1, 32'h101, 2'd3, 32'h0102_0304, 0, 1);
        run_access(1'b1, 32'h102, 2'd2, 32'hA0B0_C0D0, 2, 0);
        run_access(1'b0, 32'h100, 2'd0, 32'd0, 0, 0);
        run_access(1'b0, 32'h104, 2'd0, 32'd0, NEVER, 0);
        check_eq("t4_err", 32'(mem_error), 32'd1);

        for (int i = 0; i < 120; i++) begin
            a  = 32'($urandom_range(0, 63));
            d1 = ($urandom_range(0, 19) == 0) ? NEVER : int'($urandom_range(0, 3));
            d2 = ($urandom_range(0, 19) == 0) ? NEVER : int'($urandom_range(0, 3));
            run_access($urandom_range(0, 1) == 1, a, 2'($urandom_range(0, 3)), $urandom, d1, d2);
            repeat ($urandom_range(0, 2)) begin
                mem_ack = ($urandom_range(0, 3) == 0);
                @(negedge CLK);
            end
            mem_ack = 1'b0;
        end
        for (int w = 0; w < 16; w++)
            check_eq("final_mem", slave_rd(30'(w)), model_rd(30'(w)));
        check_stats(exp_loads, exp_stores, exp_stalls);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
